ifetch_ctrl: RTL and testbench

- Instruction-fetch controller that sequences the combinational-read instruction memory for the pipelined core.
- Owns the fetch PC and drives the memory address.
- Captures each returned word with its PC into a 2-entry fetch queue and hands entries to the decode stage over a valid/ready handshake.
- Handles branch/jump redirects, decode back-pressure and halt.

---
 rtl/ifetch_ctrl.sv | 109 ++++++++++
 tb/tb_ifetch_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_ctrl.sv
// rtl/ifetch_ctrl.sv - instruction-fetch controller with 2-entry fetch queue
module ifetch_ctrl #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(0),
  parameter logic [ADDR_WIDTH-1:0] PC_INC     = ADDR_WIDTH'(1)
) (
  input  logic                  clk_phase1_i,
  input  logic                  rst_n_i,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_data_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_pc_o,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  input  logic                  halt_i,
  output logic                  halted_o,
  output logic [31:0]           fetch_cnt_o
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [1:0]            r_count;
  logic                  r_head;
  logic [ADDR_WIDTH-1:0] r_q_pc   [2];
  logic [DATA_WIDTH-1:0] r_q_data [2];
  logic [31:0]           r_fetch_cnt;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_tail;

  // A pop only happens when the head is valid; the tail slot is head+count
  // modulo 2, which for a full queue is the slot being popped this cycle.
  assign w_pop  = (r_count != 2'd0) & inst_ready_i;
  assign w_tail = r_head ^ r_count[0];

  // State register.
  always_ff @(posedge clk_phase1_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= S_BOOT;
    else          r_state <= w_state_nxt;
  end

  // Next-state and push decision; redirect dominates halt in every state.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      S_BOOT: begin
        if (redirect_i)  w_state_nxt = S_RUN;
        else if (halt_i) w_state_nxt = S_HALT;
        else             w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!redirect_i) begin
          w_push = !halt_i & ((r_count != 2'd2) | w_pop);
          if (halt_i) w_state_nxt = S_HALT;
        end
      end
      S_HALT: begin
        if (redirect_i) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  // Fetch PC, queue storage and push counter; redirect flushes the queue.
  always_ff @(posedge clk_phase1_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_fetch_pc  <= RESET_PC;
      r_count     <= 2'd0;
      r_head      <= 1'b0;
      r_fetch_cnt <= 32'd0;
      r_q_pc[0]   <= '0;
      r_q_pc[1]   <= '0;
      r_q_data[0] <= '0;
      r_q_data[1] <= '0;
    end else if (redirect_i) begin
      r_fetch_pc <= redirect_pc_i;
      r_count    <= 2'd0;
      r_head     <= 1'b0;
    end else begin
      if (w_push) begin
        r_q_pc[w_tail]   <= r_fetch_pc;
        r_q_data[w_tail] <= imem_data_i;
        r_fetch_pc       <= r_fetch_pc + PC_INC;
        r_fetch_cnt      <= r_fetch_cnt + 32'd1;
      end
      if (w_pop) r_head <= ~r_head;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign imem_addr_o  = r_fetch_pc;
  assign inst_valid_o = (r_count != 2'd0);
  assign inst_o       = inst_valid_o ? r_q_data[r_head] : '0;
  assign inst_pc_o    = inst_valid_o ? r_q_pc[r_head]   : '0;
  assign halted_o     = (r_state == S_HALT) & (r_count == 2'd0);
  assign fetch_cnt_o  = r_fetch_cnt;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb/tb_ifetch_ctrl.sv - scoreboard bench for ifetch_ctrl
`timescale 1ns/1ps
module tb_ifetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;
  logic [31:0] fetch_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  ifetch_ctrl dut (
    .clk_phase1_i (clk),
    .rst_n_i      (rst_n),
    .imem_addr_o  (imem_addr),
    .imem_data_i  (imem_data),
    .inst_valid_o (inst_valid),
    .inst_ready_i (inst_ready),
    .inst_o       (inst),
    .inst_pc_o    (inst_pc),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .halt_i       (halt),
    .halted_o     (halted),
    .fetch_cnt_o  (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + a;
  endfunction

  assign imem_data = mem_word(imem_addr);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  localparam logic [1:0] M_BOOT = 2'd0;
  localparam logic [1:0] M_RUN  = 2'd1;
  localparam logic [1:0] M_HALT = 2'd2;

  ent_t        exp_q[$];
  logic [31:0] m_pc    = 32'd0;
  logic [1:0]  m_state = M_BOOT;
  logic [31:0] m_cnt   = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  // Reference model: expected queue contents evolve by the handshake rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_pc    <= 32'd0;
      m_state <= M_BOOT;
      m_cnt   <= 32'd0;
    end else begin
      bit pop_m, push_m;
      pop_m  = (exp_q.size() > 0) && inst_ready;
      if (redirect) begin
        exp_q.delete();
        m_pc    <= redirect_pc;
        m_state <= M_RUN;
      end else begin
        push_m = (m_state == M_RUN) && !halt && ((exp_q.size() < 2) || pop_m);
        if (pop_m) void'(exp_q.pop_front());
        if (push_m) begin
          exp_q.push_back('{pc: m_pc, data: mem_word(m_pc)});
          m_pc  <= m_pc + 32'd1;
          m_cnt <= m_cnt + 32'd1;
        end
        if (m_state != M_HALT && halt) m_state <= M_HALT;
        else if (m_state == M_BOOT)    m_state <= M_RUN;
      end
    end
  end

  // Monitor: compare DUT outputs with the scoreboard head away from the edge.
  always @(negedge clk) begin
    check("imem_addr", imem_addr, m_pc);
    check("fetch_cnt", fetch_cnt, m_cnt);
    check("halted", {31'd0, halted}, {31'd0, (m_state == M_HALT) && (exp_q.size() == 0)});
    check("inst_valid", {31'd0, inst_valid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      check("inst_pc", inst_pc, exp_q[0].pc);
      check("inst", inst, exp_q[0].data);
    end else begin
      check("inst_pc_empty", inst_pc, 32'd0);
      check("inst_empty", inst, 32'd0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    step(1);
    redirect    = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    inst_ready  = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    halt        = 1'b0;
    step(3);
    rst_n = 1'b1;

    // Stream, then back-pressure and release.
    step(5);
    inst_ready = 1'b0;
    step(5);
    inst_ready = 1'b1;
    step(8);

    // Redirect while full.
    inst_ready = 1'b0;
    step(3);
    do_redirect(32'h0000_0100);
    inst_ready = 1'b1;
    step(6);

    // Halt with two entries queued, drain, halt release does not resume.
    inst_ready = 1'b0;
    step(3);
    halt       = 1'b1;
    inst_ready = 1'b1;
    step(5);
    halt = 1'b0;
    step(3);
    do_redirect(32'h0000_0020);
    step(5);

    // PC wrap through all-ones.
    do_redirect(32'hFFFF_FFFE);
    step(5);

    // Redirect and halt together, halt held afterwards.
    halt = 1'b1;
    do_redirect(32'h0000_0040);
    step(3);
    halt = 1'b0;
    do_redirect(32'h0000_0050);
    step(4);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      inst_ready  = ($urandom_range(0, 3) != 0);
      halt        = ($urandom_range(0, 9) == 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                                : 32'($urandom);
      step(1);
    end
    redirect   = 1'b0;
    halt       = 1'b0;
    inst_ready = 1'b1;
    do_redirect(32'h0000_1000);
    step(4);

    // Asynchronous reset in mid-stream takes effect without a clock edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_valid", {31'd0, inst_valid}, 32'd0);
    check("async_fetch_cnt", fetch_cnt, 32'd0);
    check("async_addr", imem_addr, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
